bias_act_quant: RTL

BIAS_ACT_QUANT -- requirements
Module: bias_act_quant

---
 rtl/bias_act_quant_pkg.sv | 17 +
 rtl/bias_act_quant_if.sv | 34 +++
 rtl/bias_act_quant_act_lane.sv | 39 +++
 rtl/bias_act_quant.sv | 116 +++++++++++
 4 files changed

// File: rtl/bias_act_quant_pkg.sv
// Shared definitions for the bias / activation / requantization block.
// Holds the FSM state encoding and the default parameter values used by
// the interface, the top module and the testbench.
package bias_act_quant_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PROCESS = 2'b01,
        HOLD    = 2'b10
    } state_e;

    localparam int DEF_SIZE      = 6;
    localparam int DEF_ACC_WIDTH = 20;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_SHIFT     = 4;

endpackage

// File: rtl/bias_act_quant_if.sv
// Handshake bundle between the matrix-vector multiplier, this block and the
// downstream consumer.
//   in_valid / in_ready    : input vector handshake
//   in_vector / bias       : SIZE signed ACC_WIDTH-bit elements each
//   out_valid / out_ready  : output vector handshake
//   out_vector             : SIZE unsigned WIDTH-bit results
//   sat_flags              : per-element saturate-high flags
// master = the surrounding system, slave = bias_act_quant.
interface bias_act_quant_if
    import bias_act_quant_pkg::*;
#(
    parameter int SIZE      = DEF_SIZE,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int WIDTH     = DEF_WIDTH
);
    logic                      in_valid;
    logic                      in_ready;
    logic [SIZE*ACC_WIDTH-1:0] in_vector;
    logic [SIZE*ACC_WIDTH-1:0] bias;
    logic                      out_valid;
    logic                      out_ready;
    logic [SIZE*WIDTH-1:0]     out_vector;
    logic [SIZE-1:0]           sat_flags;

    modport master (
        output in_valid, in_vector, bias, out_ready,
        input  in_ready, out_valid, out_vector, sat_flags
    );

    modport slave (
        input  in_valid, in_vector, bias, out_ready,
        output in_ready, out_valid, out_vector, sat_flags
    );
endinterface

// File: rtl/bias_act_quant_act_lane.sv
// act_lane: one element of the datapath, purely combinational.
//   acc, bias : signed ACC_WIDTH-bit inputs
//   value     : relu(acc + bias) >>> SHIFT, clamped to WIDTH unsigned bits
//   sat       : set when the clamp was applied
module act_lane #(
    parameter int ACC_WIDTH = 20,
    parameter int WIDTH     = 8,
    parameter int SHIFT     = 4
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [ACC_WIDTH-1:0] bias,
    output logic        [WIDTH-1:0]     value,
    output logic                        sat
);
    // One extra bit so the sum of two extreme operands cannot wrap.
    logic signed [ACC_WIDTH:0] sum_s;
    logic        [ACC_WIDTH:0] relu_s;
    logic        [ACC_WIDTH:0] shifted_s;

    // Add, rectify, shift and clamp one element.
    always_comb begin
        sum_s = {acc[ACC_WIDTH-1], acc} + {bias[ACC_WIDTH-1], bias};
        if (sum_s[ACC_WIDTH]) begin
            relu_s = {(ACC_WIDTH+1){1'b0}};
        end else begin
            relu_s = sum_s;
        end
        // relu_s is non-negative, so a logical shift equals the arithmetic
        // shift (floor division by 2^SHIFT).
        shifted_s = relu_s >> SHIFT;
        if (|shifted_s[ACC_WIDTH:WIDTH]) begin
            value = {WIDTH{1'b1}};
            sat   = 1'b1;
        end else begin
            value = shifted_s[WIDTH-1:0];
            sat   = 1'b0;
        end
    end
endmodule

// File: rtl/bias_act_quant.sv
// bias_act_quant: accepts a vector of signed accumulators plus biases,
// produces relu((acc + bias) >>> SHIFT) saturated to WIDTH unsigned bits,
// one element per cycle through a single shared act_lane.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : bias_act_quant_if slave modport (input/output handshakes)
// Output is presented SIZE cycles after the accepting edge and held until
// out_ready; a new vector is accepted only from IDLE.
module bias_act_quant
    import bias_act_quant_pkg::*;
#(
    parameter int SIZE      = DEF_SIZE,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SHIFT     = DEF_SHIFT
) (
    input logic             clk,
    input logic             reset,
    bias_act_quant_if.slave bus
);
    localparam int               IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

    state_e                    state_r;
    state_e                    state_leg_s;
    logic [IDX_W-1:0]          idx_r;
    logic [SIZE*ACC_WIDTH-1:0] acc_r;
    logic [SIZE*ACC_WIDTH-1:0] bias_r;
    logic [SIZE*WIDTH-1:0]     out_vector_r;
    logic [SIZE-1:0]           sat_r;

    logic signed [ACC_WIDTH-1:0] lane_acc_s;
    logic signed [ACC_WIDTH-1:0] lane_bias_s;
    logic        [WIDTH-1:0]     lane_value_s;
    logic                        lane_sat_s;

    // Fold the unused encoding onto IDLE so both decode and next-state agree.
    always_comb begin
        case (state_r)
            IDLE:    state_leg_s = IDLE;
            PROCESS: state_leg_s = PROCESS;
            HOLD:    state_leg_s = HOLD;
            default: state_leg_s = IDLE;
        endcase
    end

    // Select the captured element addressed by idx for the shared lane.
    always_comb begin
        lane_acc_s  = acc_r[int'(idx_r)*ACC_WIDTH +: ACC_WIDTH];
        lane_bias_s = bias_r[int'(idx_r)*ACC_WIDTH +: ACC_WIDTH];
    end

    act_lane #(
        .ACC_WIDTH (ACC_WIDTH),
        .WIDTH     (WIDTH),
        .SHIFT     (SHIFT)
    ) u_act_lane (
        .acc   (lane_acc_s),
        .bias  (lane_bias_s),
        .value (lane_value_s),
        .sat   (lane_sat_s)
    );

    // Control FSM, capture registers and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= {IDX_W{1'b0}};
            acc_r        <= {(SIZE*ACC_WIDTH){1'b0}};
            bias_r       <= {(SIZE*ACC_WIDTH){1'b0}};
            out_vector_r <= {(SIZE*WIDTH){1'b0}};
            sat_r        <= {SIZE{1'b0}};
        end else begin
            case (state_leg_s)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc_r        <= bus.in_vector;
                        bias_r       <= bus.bias;
                        out_vector_r <= {(SIZE*WIDTH){1'b0}};
                        sat_r        <= {SIZE{1'b0}};
                        idx_r        <= {IDX_W{1'b0}};
                        state_r      <= PROCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PROCESS: begin
                    out_vector_r[int'(idx_r)*WIDTH +: WIDTH] <= lane_value_s;
                    sat_r[idx_r]                             <= lane_sat_s;
                    // idx parks on the last element rather than wrapping.
                    if (idx_r == IDX_LAST) begin
                        state_r <= HOLD;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                        state_r <= PROCESS;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_leg_s == IDLE);
    assign bus.out_valid  = (state_r == HOLD);
    assign bus.out_vector = out_vector_r;
    assign bus.sat_flags  = sat_r;
endmodule
